// File: rtl/nabp_mapper_lut_arbiter_pkg.sv
// Shared constants and types for the NABP mapper LUT arbiter.
//   kNumRequesters  : mapper lanes sharing the LUT
//   kAngleLength    : angle width; valid angles are 0..kNumAngles-1
//   kAccuPart/Base  : widths of the fixed-point words the LUT returns
//                     (formats are owned by the LUT contents; this block
//                     only moves the bits)
//   kLutLatency     : cycles from the handshake-registered angle to LUT data
//   tag_t           : per-lookup bookkeeping carried alongside the LUT
package nabp_mapper_lut_arbiter_pkg;

  localparam int unsigned kNumRequesters  = 4;
  localparam int unsigned kAngleLength    = 8;
  localparam int unsigned kNumAngles      = 180;
  localparam int unsigned kAccuPartLength = 16;
  localparam int unsigned kAccuBaseLength = 16;
  localparam int unsigned kLutLatency     = 2;
  localparam int unsigned kLaneLength     = $clog2(kNumRequesters);

  typedef logic [kLaneLength-1:0]  lane_t;
  typedef logic [kAngleLength-1:0] angle_t;

  typedef struct packed {
    logic  valid;
    lane_t lane;
    logic  err;
  } tag_t;

  function automatic logic angle_out_of_range(input angle_t angle);
    return angle >= kAngleLength'(kNumAngles);
  endfunction

endpackage

// File: rtl/nabp_mapper_lut_arbiter_rr.sv
// Round-robin one-hot arbiter.
//   clk, reset : system clock, synchronous active-high reset
//   req        : request mask (already filtered for eligibility)
//   grant      : one-hot grant or zero, combinational
//   grant_idx  : index of the granted lane (valid when grant != 0)
// The search starts at the pointer and wraps; the pointer advances to
// granted+1 only on a grant.
module nabp_rr_arbiter #(
  parameter int unsigned kNumRequesters = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [kNumRequesters-1:0]         req,
  output logic [kNumRequesters-1:0]         grant,
  output logic [$clog2(kNumRequesters)-1:0] grant_idx
);

  localparam int unsigned kIdxLength = $clog2(kNumRequesters);

  logic [kIdxLength-1:0] ptr;
  logic [kIdxLength-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 0; off < kNumRequesters; off++) begin
      cand = kIdxLength'((32'(ptr) + off) % kNumRequesters);
      if (grant == '0 && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (32'(grant_idx) == kNumRequesters - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/nabp_mapper_lut_arbiter.sv
// Shares one NABP mapper LUT among kNumRequesters mapper lanes.
//   clk, reset          : system clock, synchronous active-high reset
//   req_valid/req_angle : per-lane lookup requests (lane i angle at [i*W +: W])
//   req_ready           : one-hot grant, transfer on valid&ready
//   lut_angle           : registered angle to the LUT
//   lut_accu_part/base  : LUT outputs
//   rsp_valid           : one-hot response strobe per lane
//   rsp_err             : response was for an angle >= kNumAngles
//   rsp_accu_part/base  : registered LUT data (zero on err)
module nabp_mapper_lut_arbiter
  import nabp_mapper_lut_arbiter_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [kNumRequesters-1:0]              req_valid,
  input  logic [kNumRequesters*kAngleLength-1:0] req_angle,
  output logic [kNumRequesters-1:0]              req_ready,
  output logic [kAngleLength-1:0]                lut_angle,
  input  logic [kAccuPartLength-1:0]             lut_accu_part,
  input  logic [kAccuBaseLength-1:0]             lut_accu_base,
  output logic [kNumRequesters-1:0]              rsp_valid,
  output logic                                   rsp_err,
  output logic [kAccuPartLength-1:0]             rsp_accu_part,
  output logic [kAccuBaseLength-1:0]             rsp_accu_base
);

  logic [kNumRequesters-1:0] outstanding;
  logic [kNumRequesters-1:0] eligible;
  logic [kNumRequesters-1:0] grant;
  lane_t                     grant_idx;
  angle_t                    angle_arr [kNumRequesters];
  angle_t                    grant_angle;
  logic                      grant_any;
  logic                      grant_err;
  tag_t                      tag_pipe [kLutLatency];

  always_comb begin
    for (int unsigned i = 0; i < kNumRequesters; i++) begin
      angle_arr[i] = req_angle[i*kAngleLength +: kAngleLength];
    end
  end

  // Reset masks eligibility so req_ready reads zero while reset is held.
  assign eligible = req_valid & ~outstanding & {kNumRequesters{~reset}};

  nabp_rr_arbiter #(
    .kNumRequesters(kNumRequesters)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready   = grant;
  assign grant_any   = |grant;
  assign grant_angle = angle_arr[grant_idx];
  assign grant_err   = angle_out_of_range(grant_angle);

  // The tag pipeline has kLutLatency explicit stages; the response
  // registers form the final stage, giving 1+kLutLatency in total.
  always_ff @(posedge clk) begin
    if (reset) begin
      lut_angle     <= '0;
      outstanding   <= '0;
      rsp_valid     <= '0;
      rsp_err       <= 1'b0;
      rsp_accu_part <= '0;
      rsp_accu_base <= '0;
      for (int unsigned k = 0; k < kLutLatency; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      if (grant_any && !grant_err) begin
        lut_angle <= grant_angle;
      end
      tag_pipe[0] <= tag_t'{valid: grant_any, lane: grant_idx, err: grant_err};
      for (int unsigned k = 1; k < kLutLatency; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end

      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (tag_pipe[kLutLatency-1].valid) begin
        rsp_valid[tag_pipe[kLutLatency-1].lane] <= 1'b1;
        rsp_err       <= tag_pipe[kLutLatency-1].err;
        rsp_accu_part <= tag_pipe[kLutLatency-1].err ? '0 : lut_accu_part;
        rsp_accu_base <= tag_pipe[kLutLatency-1].err ? '0 : lut_accu_base;
      end

      // A lane's flag is still set during its rsp_valid cycle, so the
      // set-wins case cannot actually arise from the arbiter.
      outstanding <= (outstanding & ~rsp_valid) | grant;
    end
  end

endmodule

// File: tb/tb_nabp_mapper_lut_arbiter.sv
module tb_nabp_mapper_lut_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_angle = '0;
  logic [3:0]  req_ready;
  logic [7:0]  lut_angle;
  logic [15:0] lut_accu_part;
  logic [15:0] lut_accu_base;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_accu_part;
  logic [15:0] rsp_accu_base;

  always #5 clk = ~clk;

  nabp_mapper_lut_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_angle     (req_angle),
    .req_ready     (req_ready),
    .lut_angle     (lut_angle),
    .lut_accu_part (lut_accu_part),
    .lut_accu_base (lut_accu_base),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_accu_part (rsp_accu_part),
    .rsp_accu_base (rsp_accu_base)
  );

  // LUT stand-in: data for angle a appears one cycle after a is on lut_angle.
  function automatic logic [15:0] part_of(input logic [7:0] a);
    return {a, a ^ 8'hA5};
  endfunction
  function automatic logic [15:0] base_of(input logic [7:0] a);
    return 16'(a) * 16'd97 + 16'd3;
  endfunction

  logic [7:0] lut_q = '0;
  always @(posedge clk) lut_q <= lut_angle;
  assign lut_accu_part = part_of(lut_q);
  assign lut_accu_base = base_of(lut_q);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected responses with the cycle they are due.
  typedef struct {
    int         due;
    int         lane;
    bit         err;
    logic [7:0] angle;
  } pend_t;

  pend_t      pend[$];
  int         cyc = 0;
  int         m_ptr = 0;
  bit [3:0]   m_busy = '0;
  logic [7:0] m_lut_angle = '0;
  int         lane1_grants = 0;

  task automatic run_cycle(input bit rst, input logic [3:0] v, input logic [31:0] angles);
    int         exp_lane;
    int         l;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    logic [7:0] a;
    bit         have_rsp;
    pend_t      r;
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_angle = angles;
    #1;
    exp_lane = -1;
    if (!rst) begin
      for (int off = 0; off < 4; off++) begin
        l = (m_ptr + off) % 4;
        if (exp_lane < 0 && v[l] && !m_busy[l]) exp_lane = l;
      end
    end
    exp_ready = (exp_lane >= 0) ? 4'(1 << exp_lane) : 4'b0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("lut_angle", 32'(lut_angle), 32'(m_lut_angle));

    have_rsp = pend.size() > 0 && pend[0].due == cyc;
    exp_rsp  = have_rsp ? 4'(1 << pend[0].lane) : 4'b0;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (have_rsp) begin
      r = pend.pop_front();
      check("rsp_err", 32'(rsp_err), 32'(r.err));
      check("rsp_accu_part", 32'(rsp_accu_part), r.err ? 32'd0 : 32'(part_of(r.angle)));
      check("rsp_accu_base", 32'(rsp_accu_base), r.err ? 32'd0 : 32'(base_of(r.angle)));
      m_busy[r.lane] = 1'b0;
    end else begin
      check("rsp_err_idle", 32'(rsp_err), 32'd0);
    end

    if (rst) begin
      pend.delete();
      m_busy      = '0;
      m_ptr       = 0;
      m_lut_angle = '0;
    end else if (exp_lane >= 0) begin
      a = angles[exp_lane*8 +: 8];
      pend.push_back('{due: cyc + 3, lane: exp_lane, err: (a >= 8'd180), angle: a});
      m_busy[exp_lane] = 1'b1;
      m_ptr = (exp_lane + 1) % 4;
      if (a < 8'd180) m_lut_angle = a;
      if (exp_lane == 1) lane1_grants++;
    end
    cyc++;
  endtask

  function automatic logic [7:0] rand_angle();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(180, 255));
    return 8'($urandom_range(0, 179));
  endfunction

  function automatic logic [31:0] rand_angles();
    return {rand_angle(), rand_angle(), rand_angle(), rand_angle()};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    run_cycle(1'b1, 4'b0000, '0);

    // Single lookup on lane 0, angle 45, then drain.
    run_cycle(1'b0, 4'b0001, 32'd45);
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    // All lanes request 0,1,2,3 continuously.
    repeat (20) run_cycle(1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0});
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    // Lane 2 out-of-range angles.
    run_cycle(1'b0, 4'b0100, {8'd0, 8'd180, 8'd0, 8'd0});
    repeat (4) run_cycle(1'b0, 4'b0000, '0);
    run_cycle(1'b0, 4'b0100, {8'd0, 8'd255, 8'd0, 8'd0});
    repeat (4) run_cycle(1'b0, 4'b0000, '0);

    // Move pointer to lane 3 (grant lane 2), then only lanes 1 and 3 request.
    run_cycle(1'b0, 4'b0100, {8'd0, 8'd7, 8'd0, 8'd0});
    repeat (4) run_cycle(1'b0, 4'b0000, '0);
    repeat (24) run_cycle(1'b0, 4'b1010, {8'($urandom_range(0, 179)), 8'd0, 8'($urandom_range(0, 179)), 8'd0});
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    // Reset with lookups in flight.
    repeat (3) run_cycle(1'b0, 4'b1111, rand_angles());
    repeat (2) run_cycle(1'b1, 4'b1111, rand_angles());
    repeat (4) run_cycle(1'b0, 4'b0000, '0);
    run_cycle(1'b0, 4'b0001, 32'd90);
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    // Lane 1 holds angle 179.
    lane1_grants = 0;
    repeat (40) run_cycle(1'b0, 4'b0010, {8'd0, 8'd0, 8'd179, 8'd0});
    check("lane1_grant_count", 32'(lane1_grants), 32'd10);
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 99) == 0), 4'($urandom), rand_angles());
    end
    repeat (5) run_cycle(1'b0, 4'b0000, '0);

    check("pending_drained", 32'(pend.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
